// File: rtl/pe_feeder_pkg.sv
// ============================================================================
// Module  : pe_feeder_pkg
// Brief   : Shared state encoding and sizing constants for the PE fmap feeder.
// Revision: 1.0
// ============================================================================
`default_nettype none

package pe_feeder_pkg;

    localparam int DEFAULT_DATA_WIDTH = 16;
    localparam int DEFAULT_ADDR_WIDTH = 8;
    localparam int DEFAULT_CNT_WIDTH  = 8;

    localparam int SKID_DEPTH = 2;
    localparam int OCC_WIDTH  = $clog2(SKID_DEPTH + 1);
    localparam int PTR_WIDTH  = $clog2(SKID_DEPTH);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START      = 3'd1,
        STREAM     = 3'd2,
        WAIT_SHIFT = 3'd3,
        DONE       = 3'd4
    } feeder_state_t;

endpackage

`default_nettype wire

// File: rtl/feeder_skid_buf.sv
// ============================================================================
// Module  : feeder_skid_buf
// Brief   : Two-entry FIFO that absorbs SRAM read data while the PE is full.
// Revision: 1.0
// ============================================================================
`default_nettype none

module feeder_skid_buf
    import pe_feeder_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic                  head_valid,
    output logic [OCC_WIDTH-1:0]  occupancy
);

    logic [DATA_WIDTH-1:0] r_mem [SKID_DEPTH];
    logic [PTR_WIDTH-1:0]  r_wr_ptr;
    logic [PTR_WIDTH-1:0]  r_rd_ptr;
    logic [OCC_WIDTH-1:0]  r_count;
    logic                  w_push;
    logic                  w_pop;

    assign w_push = push && (r_count != OCC_WIDTH'(SKID_DEPTH));
    assign w_pop  = pop && (r_count != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SKID_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            // Push and pop together leave the count unchanged.
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign head       = r_mem[r_rd_ptr];
    assign head_valid = (r_count != '0);
    assign occupancy  = r_count;

endmodule

`default_nettype wire

// File: rtl/pe_fmap_feeder.sv
// ============================================================================
// Module  : pe_fmap_feeder
// Brief   : Streams multi-segment fmap loads from SRAM into one PE fmap FIFO.
//           Define FEEDER_PERF_CNT_EN to add the stall_cycles counter port.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pe_fmap_feeder
    import pe_feeder_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_start,
    input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
    input  logic [CNT_WIDTH-1:0]  cfg_seg_len,
    input  logic [CNT_WIDTH-1:0]  cfg_seg_num,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  start_feature_load,
    output logic                  load_full_cloumn,
    output logic [DATA_WIDTH-1:0] feature_in,
    output logic                  feature_in_en,
    input  logic                  fifo_full_fmap,
    input  logic                  shift_finish_flg
`ifdef FEEDER_PERF_CNT_EN
    ,
    output logic [31:0]           stall_cycles
`endif
);

    feeder_state_t r_state;
    feeder_state_t w_state_next;

    logic [ADDR_WIDTH-1:0] r_addr;
    logic [CNT_WIDTH-1:0]  r_seg_len;
    logic [CNT_WIDTH-1:0]  r_seg_num;
    logic [CNT_WIDTH-1:0]  r_issued;
    logic [CNT_WIDTH-1:0]  r_accepted;
    logic [CNT_WIDTH-1:0]  r_seg_done;
    logic                  r_zero_job;
    logic                  r_inflight;
    logic                  r_load_full;

    logic                  w_cfg_accept;
    logic                  w_rd_en;
    logic                  w_pop;
    logic                  w_head_valid;
    logic [DATA_WIDTH-1:0] w_head;
    logic [OCC_WIDTH-1:0]  w_occ;
    logic [OCC_WIDTH:0]    w_fill;
    logic [CNT_WIDTH:0]    w_acc_next;
    logic [CNT_WIDTH:0]    w_seg_done_next;
    logic                  w_seg_end;
    logic                  w_more_segs;
    logic                  w_start_pulse;

    feeder_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk        (clk),
        .rst        (rst),
        .push       (r_inflight),
        .push_data  (mem_rd_data),
        .pop        (w_pop),
        .head       (w_head),
        .head_valid (w_head_valid),
        .occupancy  (w_occ)
    );

    assign w_cfg_accept = (r_state == IDLE) && cfg_start;
    assign w_pop        = w_head_valid && !fifo_full_fmap;

    // Slots committed at the next edge; a new read is only issued if it is
    // guaranteed a free entry when its data lands.
    assign w_fill  = {1'b0, w_occ} + {{OCC_WIDTH{1'b0}}, r_inflight}
                   - {{OCC_WIDTH{1'b0}}, w_pop};
    assign w_rd_en = (r_state == STREAM) && (r_issued < r_seg_len)
                   && (w_fill < (OCC_WIDTH + 1)'(SKID_DEPTH));

    assign w_acc_next      = {1'b0, r_accepted} + {{CNT_WIDTH{1'b0}}, w_pop};
    assign w_seg_end       = (r_state == STREAM) && (w_acc_next == {1'b0, r_seg_len});
    assign w_seg_done_next = {1'b0, r_seg_done} + {{CNT_WIDTH{1'b0}}, 1'b1};
    assign w_more_segs     = (w_seg_done_next < {1'b0, r_seg_num});
    assign w_start_pulse   = (r_state == START) && !r_zero_job;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:       if (cfg_start) w_state_next = START;
            START:      w_state_next = r_zero_job ? DONE : STREAM;
            STREAM:     if (w_seg_end) w_state_next = w_more_segs ? WAIT_SHIFT : DONE;
            WAIT_SHIFT: if (shift_finish_flg) w_state_next = START;
            DONE:       w_state_next = IDLE;
            default:    w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_seg_len   <= '0;
            r_seg_num   <= '0;
            r_issued    <= '0;
            r_accepted  <= '0;
            r_seg_done  <= '0;
            r_zero_job  <= 1'b0;
            r_inflight  <= 1'b0;
            r_load_full <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_inflight <= w_rd_en;

            if (w_cfg_accept) begin
                r_addr     <= cfg_base_addr;
                r_seg_len  <= cfg_seg_len;
                r_seg_num  <= cfg_seg_num;
                r_seg_done <= '0;
                r_zero_job <= (cfg_seg_len == '0) || (cfg_seg_num == '0);
            end

            if (r_state == START) begin
                r_issued   <= '0;
                r_accepted <= '0;
            end

            // The address keeps running across segments and wraps naturally.
            if (w_rd_en) begin
                r_issued <= r_issued + 1'b1;
                r_addr   <= r_addr + 1'b1;
            end

            if (r_state == STREAM) begin
                r_accepted <= w_acc_next[CNT_WIDTH-1:0];
            end

            if (w_seg_end) begin
                r_seg_done <= w_seg_done_next[CNT_WIDTH-1:0];
            end

            if (w_start_pulse) begin
                r_load_full <= 1'b1;
            end else if (w_state_next == DONE) begin
                r_load_full <= 1'b0;
            end
        end
    end

`ifdef FEEDER_PERF_CNT_EN
    logic [31:0] r_stall_cycles;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= '0;
        end else if (w_cfg_accept) begin
            r_stall_cycles <= '0;
        end else if (w_head_valid && fifo_full_fmap && (r_stall_cycles != '1)) begin
            r_stall_cycles <= r_stall_cycles + 1'b1;
        end
    end

    assign stall_cycles = r_stall_cycles;
`endif

    assign busy               = (r_state != IDLE);
    assign done               = (r_state == DONE);
    assign mem_rd_en          = w_rd_en;
    assign mem_rd_addr        = r_addr;
    assign start_feature_load = w_start_pulse;
    assign load_full_cloumn   = r_load_full | w_start_pulse;
    assign feature_in         = w_head_valid ? w_head : '0;
    assign feature_in_en      = w_pop;

endmodule

`default_nettype wire

// File: tb/tb_pe_fmap_feeder.sv
// ============================================================================
// Module  : tb_pe_fmap_feeder
// Brief   : Directed vector bench for pe_fmap_feeder with an SRAM model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pe_fmap_feeder;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_start;
    logic [7:0]  cfg_base_addr;
    logic [7:0]  cfg_seg_len;
    logic [7:0]  cfg_seg_num;
    logic        busy;
    logic        done;
    logic        mem_rd_en;
    logic [7:0]  mem_rd_addr;
    logic [15:0] mem_rd_data;
    logic        start_feature_load;
    logic        load_full_cloumn;
    logic [15:0] feature_in;
    logic        feature_in_en;
    logic        fifo_full_fmap;
    logic        shift_finish_flg;
`ifdef FEEDER_PERF_CNT_EN
    logic [31:0] stall_cycles;
`endif

    pe_fmap_feeder dut (
        .clk                (clk),
        .rst                (rst),
        .cfg_start          (cfg_start),
        .cfg_base_addr      (cfg_base_addr),
        .cfg_seg_len        (cfg_seg_len),
        .cfg_seg_num        (cfg_seg_num),
        .busy               (busy),
        .done               (done),
        .mem_rd_en          (mem_rd_en),
        .mem_rd_addr        (mem_rd_addr),
        .mem_rd_data        (mem_rd_data),
        .start_feature_load (start_feature_load),
        .load_full_cloumn   (load_full_cloumn),
        .feature_in         (feature_in),
        .feature_in_en      (feature_in_en),
        .fifo_full_fmap     (fifo_full_fmap),
        .shift_finish_flg   (shift_finish_flg)
`ifdef FEEDER_PERF_CNT_EN
        ,
        .stall_cycles       (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model: word at address a holds a+1, one-cycle read latency.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= 16'(mem_rd_addr) + 16'd1;
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    int got_q[$];
    int en_rel_q[$];
    int rd_addr_q[$];
    int rd_rel_q[$];
    int start_rel_q[$];
    int n_done, done_rel, n_busy, n_lf_err, max_fill, n_rd_tot, n_acc_tot;
    int job_c0, cur_len, cur_total, cur_delay, shift_at, mrel, fill;
    bit mon_en = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            mrel = cyc - job_c0;
            fill = n_rd_tot - n_acc_tot - (feature_in_en ? 1 : 0) + (mem_rd_en ? 1 : 0);
            if (fill > max_fill) max_fill = fill;
            if (feature_in_en) begin
                got_q.push_back(int'(feature_in));
                en_rel_q.push_back(mrel);
                n_acc_tot++;
                if (cur_len != 0 && (got_q.size() % cur_len) == 0 && got_q.size() < cur_total)
                    shift_at = cyc + cur_delay;
            end
            if (mem_rd_en) begin
                rd_addr_q.push_back(int'(mem_rd_addr));
                rd_rel_q.push_back(mrel);
                n_rd_tot++;
            end
            if (start_feature_load) begin
                start_rel_q.push_back(mrel);
                if (!load_full_cloumn) n_lf_err++;
            end
            if (done) begin
                n_done++;
                done_rel = mrel;
                if (load_full_cloumn) n_lf_err++;
            end
            if (busy) n_busy++;
        end
    end

    task automatic run_job(input int base, input int len, input int num, input bit bp,
                           input int delay, input int stop_after);
        int rel;
        got_q.delete(); en_rel_q.delete(); rd_addr_q.delete();
        rd_rel_q.delete(); start_rel_q.delete();
        n_done = 0; done_rel = -1; n_busy = 0; n_lf_err = 0; max_fill = 0;
        n_rd_tot = 0; n_acc_tot = 0; shift_at = -1;
        cur_len = len; cur_total = len * num; cur_delay = delay;
        @(posedge clk); #1;
        cfg_base_addr    = base[7:0];
        cfg_seg_len      = len[7:0];
        cfg_seg_num      = num[7:0];
        cfg_start        = 1'b1;
        fifo_full_fmap   = 1'b0;
        shift_finish_flg = 1'b0;
        job_c0 = cyc;
        mon_en = 1'b1;
        for (int t = 0; t < 600; t++) begin
            @(posedge clk); #1;
            cfg_start = 1'b0;
            rel = cyc - job_c0;
            fifo_full_fmap   = bp && ((rel >= 5 && rel <= 9) || (rel >= 10 && (rel % 2) == 1));
            shift_finish_flg = (cyc == shift_at);
            if (stop_after > 0 && got_q.size() >= stop_after) break;
            if (n_done > 0 && rel > done_rel + 1) break;
        end
        fifo_full_fmap   = 1'b0;
        shift_finish_flg = 1'b0;
    endtask

    function automatic logic [29:0] out_vec();
        return {busy, done, mem_rd_en, mem_rd_addr, start_feature_load,
                load_full_cloumn, feature_in, feature_in_en};
    endfunction

    typedef struct {
        int base;
        int len;
        int num;
        bit bp;
        int delay;
        int exp_done;   // -1: timing not checked
    } vec_t;

    vec_t vecs[6];

    initial begin
        int exp_words, n, seg_end, win_rd, win_st;

        rst = 1'b1; cfg_start = 1'b0; cfg_base_addr = '0; cfg_seg_len = '0;
        cfg_seg_num = '0; fifo_full_fmap = 1'b0; shift_finish_flg = 1'b0;

        vecs[0] = '{base: 0,   len: 12, num: 3, bp: 1'b0, delay: 20, exp_done: 86};
        vecs[1] = '{base: 0,   len: 12, num: 1, bp: 1'b1, delay: 0,  exp_done: -1};
        vecs[2] = '{base: 250, len: 12, num: 1, bp: 1'b0, delay: 0,  exp_done: 16};
        vecs[3] = '{base: 0,   len: 0,  num: 3, bp: 1'b0, delay: 0,  exp_done: 2};
        vecs[4] = '{base: 7,   len: 5,  num: 0, bp: 1'b0, delay: 0,  exp_done: 2};
        vecs[5] = '{base: 100, len: 4,  num: 2, bp: 1'b0, delay: 50, exp_done: 65};

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", int'(out_vec()), 0);
        rst = 1'b0;

        for (int v = 0; v < 6; v++) begin
            run_job(vecs[v].base, vecs[v].len, vecs[v].num, vecs[v].bp, vecs[v].delay, 0);
            exp_words = vecs[v].len * vecs[v].num;
            check($sformatf("v%0d_word_count", v), got_q.size(), exp_words);
            n = (got_q.size() < exp_words) ? got_q.size() : exp_words;
            for (int i = 0; i < n; i++)
                check($sformatf("v%0d_word%0d", v, i), got_q[i], ((vecs[v].base + i) % 256) + 1);
            check($sformatf("v%0d_read_count", v), rd_addr_q.size(), exp_words);
            n = (rd_addr_q.size() < exp_words) ? rd_addr_q.size() : exp_words;
            for (int i = 0; i < n; i++)
                check($sformatf("v%0d_rd_addr%0d", v, i), rd_addr_q[i], (vecs[v].base + i) % 256);
            check($sformatf("v%0d_start_pulses", v), start_rel_q.size(),
                  (exp_words > 0) ? vecs[v].num : 0);
            check($sformatf("v%0d_done_pulses", v), n_done, 1);
            check($sformatf("v%0d_skid_fill_le2", v), (max_fill <= 2) ? 1 : 0, 1);
            check($sformatf("v%0d_load_full_flag", v), n_lf_err, 0);
            if (vecs[v].exp_done >= 0) begin
                check($sformatf("v%0d_done_cycle", v), done_rel, vecs[v].exp_done);
                check($sformatf("v%0d_busy_cycles", v), n_busy, vecs[v].exp_done);
            end
            if (vecs[v].exp_done >= 0 && exp_words > 0 && start_rel_q.size() > 0
                && rd_rel_q.size() > 0 && en_rel_q.size() > 0) begin
                check($sformatf("v%0d_first_start", v), start_rel_q[0], 1);
                check($sformatf("v%0d_first_read", v), rd_rel_q[0], 2);
                check($sformatf("v%0d_first_en", v), en_rel_q[0], 4);
            end
            if (vecs[v].delay >= 50 && en_rel_q.size() >= vecs[v].len && start_rel_q.size() > 1) begin
                seg_end = en_rel_q[vecs[v].len - 1];
                win_rd = 0;
                win_st = 0;
                foreach (rd_rel_q[i])
                    if (rd_rel_q[i] > seg_end && rd_rel_q[i] <= seg_end + vecs[v].delay) win_rd++;
                foreach (start_rel_q[i])
                    if (start_rel_q[i] > seg_end && start_rel_q[i] <= seg_end + vecs[v].delay) win_st++;
                check("slow_shift_no_reads", win_rd, 0);
                check("slow_shift_no_start", win_st, 0);
                check("slow_shift_start_after_flag", start_rel_q[1], seg_end + vecs[v].delay + 1);
            end
            mon_en = 1'b0;
        end

        // Reset while the sixth word of a 12-word segment is at the head.
        run_job(40, 12, 1, 1'b0, 0, 5);
        check("midreset_words_before", got_q.size(), 5);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midreset_outputs", int'(out_vec()), 0);
        rst = 1'b0;
        mon_en = 1'b0;

        run_job(60, 6, 1, 1'b0, 0, 0);
        check("post_reset_word_count", got_q.size(), 6);
        n = (got_q.size() < 6) ? got_q.size() : 6;
        for (int i = 0; i < n; i++)
            check($sformatf("post_reset_word%0d", i), got_q[i], 61 + i);
        check("post_reset_done_cycle", done_rel, 10);
        mon_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
